// File: rtl/afifo_reader_fast_merge.sv
// Fast-clock reader for the slow-to-fast FIFO bank: pops FIFO heads in row-index
// order and emits one sorted word per cycle through a registered valid/ready output.
module afifo_reader_fast_merge #(
    parameter int   DATA_WIDTH_ADD_STG = 16,
    parameter int   NUM_SLOW_BLK       = 4,
    parameter int   BITS_ROW_IDX       = 8,
    parameter logic MODE_WORK          = 1'b1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       unit_en,
    input  logic                                       mode,
    input  logic [NUM_SLOW_BLK-1:0]                    fifo_empty,
    input  logic [NUM_SLOW_BLK*DATA_WIDTH_ADD_STG-1:0] data_out_fifo,
    input  logic [NUM_SLOW_BLK-1:0]                    blk_done,
    input  logic                                       out_ready,
    output logic                                       next_stg_rd_en,
    output logic [NUM_SLOW_BLK-1:0]                    en_intake_fifo_slow_blk,
    output logic [DATA_WIDTH_ADD_STG-1:0]              data_out,
    output logic                                       data_out_valid,
    output logic                                       merge_done,
    output logic                                       order_err
);

    localparam int W = DATA_WIDTH_ADD_STG;

    typedef enum logic [1:0] {S_IDLE, S_MERGE, S_DRAIN, S_DONE} state_t;

    state_t                  state, state_next;
    logic [NUM_SLOW_BLK-1:0] lane_ready, lane_fin, lane_settled, sel_onehot;
    logic [W-1:0]            lane_word, sel_word;
    logic [BITS_ROW_IDX-1:0] best_row, last_row;
    logic                    found, slot_free, pop, mode_work;

    assign lane_ready   = ~fifo_empty;
    assign lane_fin     = fifo_empty & blk_done;
    assign lane_settled = lane_ready | lane_fin;
    assign slot_free    = !data_out_valid || out_ready;
    assign mode_work    = (mode == MODE_WORK);

    // Minimum row among non-empty heads; strict compare keeps the lowest lane on ties.
    always_comb begin
        found      = 1'b0;
        best_row   = '0;
        sel_onehot = '0;
        sel_word   = '0;
        lane_word  = '0;
        for (int i = 0; i < NUM_SLOW_BLK; i++) begin
            lane_word = data_out_fifo[i*W +: W];
            if (lane_ready[i] && (!found || lane_word[W-1 -: BITS_ROW_IDX] < best_row)) begin
                found         = 1'b1;
                best_row      = lane_word[W-1 -: BITS_ROW_IDX];
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
                sel_word      = lane_word;
            end
        end
    end

    // An empty lane that is not finished may still deliver a smaller row, so wait for it.
    assign pop = (state == S_MERGE) && mode_work && unit_en &&
                 (&lane_settled) && (|lane_ready) && slot_free;

    assign next_stg_rd_en          = pop;
    assign en_intake_fifo_slow_blk = pop ? sel_onehot : '0;
    assign merge_done              = (state == S_DONE) || (state == S_DRAIN && !data_out_valid);

    always_comb begin
        state_next = state;
        if (!mode_work) begin
            state_next = S_IDLE;
        end else if (unit_en) begin
            case (state)
                S_IDLE:  state_next = S_MERGE;
                S_MERGE: if (&lane_fin) state_next = S_DRAIN;
                S_DRAIN: if (!data_out_valid) state_next = S_DONE;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            last_row       <= '0;
            order_err      <= 1'b0;
        end else begin
            state <= state_next;
            if (!mode_work) begin
                data_out_valid <= 1'b0;
            end else begin
                if (data_out_valid && out_ready)
                    data_out_valid <= 1'b0;
                // Heads with the valid bit clear are consumed silently.
                if (pop && sel_word[0]) begin
                    data_out       <= sel_word;
                    data_out_valid <= 1'b1;
                    if (best_row < last_row)
                        order_err <= 1'b1;
                    last_row <= best_row;
                end
            end
        end
    end

endmodule

// File: tb/tb_afifo_reader_fast_merge.sv
// Directed bench for afifo_reader_fast_merge: queue-level FIFO model plus a
// behavioural reference checked every cycle, with literal spot checks.
module tb_afifo_reader_fast_merge;

    localparam int W = 16;
    localparam int N = 4;
    localparam int R = 8;
    localparam int D = 8;

    logic           clk = 1'b0;
    logic           rst, unit_en, mode, out_ready;
    logic [N-1:0]   fifo_empty, blk_done, en_intake;
    logic [N*W-1:0] data_out_fifo;
    logic           next_stg_rd_en, data_out_valid, merge_done, order_err;
    logic [W-1:0]   data_out;

    always #5 clk = ~clk;

    afifo_reader_fast_merge #(
        .DATA_WIDTH_ADD_STG(W), .NUM_SLOW_BLK(N), .BITS_ROW_IDX(R), .MODE_WORK(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .unit_en(unit_en), .mode(mode),
        .fifo_empty(fifo_empty), .data_out_fifo(data_out_fifo), .blk_done(blk_done),
        .out_ready(out_ready), .next_stg_rd_en(next_stg_rd_en),
        .en_intake_fifo_slow_blk(en_intake), .data_out(data_out),
        .data_out_valid(data_out_valid), .merge_done(merge_done), .order_err(order_err)
    );

    logic [W-1:0] fmem [N][D];
    int           frd [N];
    int           fwr [N];

    int           tests = 0;
    int           fails = 0;

    int           m_state;
    logic         m_valid, m_err;
    logic [W-1:0] m_data;
    logic [R-1:0] m_last;

    int           cyc = 0;
    int           last_pop_cyc, done_cyc, n_rec;
    logic [R-1:0] rec_row [16];
    int           rec_cyc [16];

    function automatic logic [W-1:0] mk(input logic [7:0] row, input logic v);
        return {row, 7'h2a, v};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int lane, input logic [W-1:0] w);
        fmem[lane][fwr[lane]] = w;
        fwr[lane]++;
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < N; i++) begin
            frd[i] = 0;
            fwr[i] = 0;
        end
    endtask

    task automatic drive_fifos();
        for (int i = 0; i < N; i++) begin
            fifo_empty[i] = (frd[i] == fwr[i]);
            data_out_fifo[i*W +: W] = (frd[i] == fwr[i]) ? '0 : fmem[i][frd[i]];
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_data  = '0;
        m_last  = '0;
    endtask

    // One clock: compare everything against the model, then advance the model.
    task automatic step();
        logic [N-1:0] ready, fin, exp_en;
        logic [W-1:0] w, hw;
        logic [R-1:0] best;
        logic         exp_pop, exp_done, nv, ne;
        logic [W-1:0] nd;
        logic [R-1:0] nl;
        int           sel, ns;
        drive_fifos();
        #1;
        sel  = -1;
        best = '0;
        for (int i = 0; i < N; i++) begin
            ready[i] = (frd[i] != fwr[i]);
            fin[i]   = !ready[i] && blk_done[i];
            if (ready[i]) begin
                hw = fmem[i][frd[i]];
                if (sel < 0 || hw[W-1 -: R] < best) begin
                    sel  = i;
                    best = hw[W-1 -: R];
                end
            end
        end
        exp_pop  = (m_state == 1) && mode && unit_en && (&(ready | fin)) && (|ready) &&
                   (!m_valid || out_ready);
        exp_en   = '0;
        if (exp_pop) exp_en[sel] = 1'b1;
        exp_done = (m_state == 3) || (m_state == 2 && !m_valid);

        check("pop_sel", en_intake, exp_en);
        check("rd_en", next_stg_rd_en, exp_pop);
        check("valid", data_out_valid, m_valid);
        if (m_valid) check("data", data_out, m_data);
        check("merge_done", merge_done, exp_done);
        check("order_err", order_err, m_err);

        if (exp_pop) last_pop_cyc = cyc;
        if (merge_done && done_cyc < 0) done_cyc = cyc;
        if (data_out_valid && out_ready && n_rec < 16) begin
            rec_row[n_rec] = data_out[W-1 -: R];
            rec_cyc[n_rec] = cyc;
            n_rec++;
        end

        ns = m_state; nv = m_valid; nd = m_data; nl = m_last; ne = m_err;
        if (!mode) begin
            ns = 0;
            nv = 1'b0;
        end else begin
            if (m_valid && out_ready) nv = 1'b0;
            if (exp_pop) begin
                w = fmem[sel][frd[sel]];
                frd[sel]++;
                if (w[0]) begin
                    nd = w;
                    nv = 1'b1;
                    if (w[W-1 -: R] < m_last) ne = 1'b1;
                    nl = w[W-1 -: R];
                end
            end
            if (unit_en) begin
                case (m_state)
                    0: ns = 1;
                    1: if (&fin) ns = 2;
                    2: if (!m_valid) ns = 3;
                    default: ns = m_state;
                endcase
            end
        end
        @(posedge clk);
        m_state = ns; m_valid = nv; m_data = nd; m_last = nl; m_err = ne;
        cyc++;
        @(negedge clk);
    endtask

    // Asserts rst between clock edges and expects every output at zero at once.
    task automatic reset_pulse();
        #2;
        rst = 1'b1;
        #1;
        check("rst_valid", data_out_valid, 1'b0);
        check("rst_data", data_out, '0);
        check("rst_rd_en", next_stg_rd_en, 1'b0);
        check("rst_sel", en_intake, '0);
        check("rst_done", merge_done, 1'b0);
        check("rst_err", order_err, 1'b0);
        model_reset();
        clear_fifos();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; unit_en = 1'b0; out_ready = 1'b0; blk_done = '0;
        clear_fifos();
        model_reset();
        drive_fifos();
        #2;
        check("init_valid", data_out_valid, 1'b0);
        check("init_data", data_out, '0);
        check("init_sel", en_intake, '0);
        check("init_done", merge_done, 1'b0);
        check("init_err", order_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Tie between lanes 1 and 3 on row 2
        mode = 1'b1; unit_en = 1'b1; out_ready = 1'b1; blk_done = 4'b0000;
        push(0, mk(8'd5, 1'b1)); push(1, mk(8'd2, 1'b1));
        push(2, mk(8'd9, 1'b1)); push(3, mk(8'd2, 1'b1));
        step();
        drive_fifos(); #1;
        check("t1_tie_sel", en_intake, 4'b0010);
        step();
        check("t1_row", data_out[W-1 -: R], 8'd2);
        check("t1_valid", data_out_valid, 1'b1);
        step();
        drive_fifos(); #1;
        check("t1_stall", en_intake, 4'b0000);
        blk_done = 4'b1111;
        repeat (6) step();
        check("t1_done", merge_done, 1'b1);
        check("t1_err", order_err, 1'b0);
        mode = 1'b0;
        step();
        reset_pulse();

        // Empty unfinished lane blocks pops until its block reports done
        mode = 1'b1; blk_done = 4'b0000;
        push(0, mk(8'd3, 1'b1)); push(1, mk(8'd4, 1'b1)); push(3, mk(8'd5, 1'b1));
        step();
        step();
        drive_fifos(); #1;
        check("t2_blocked", en_intake, 4'b0000);
        blk_done = 4'b0100;
        drive_fifos(); #1;
        check("t2_resume", en_intake, 4'b0001);
        step();
        blk_done = 4'b1111;
        repeat (5) step();
        mode = 1'b0;
        step();
        reset_pulse();

        // Full merge of {1,4},{2,3},{},{6}
        mode = 1'b1; blk_done = 4'b1111; out_ready = 1'b1;
        push(0, mk(8'd1, 1'b1)); push(0, mk(8'd4, 1'b1));
        push(1, mk(8'd2, 1'b1)); push(1, mk(8'd3, 1'b1));
        push(3, mk(8'd6, 1'b1));
        n_rec = 0; last_pop_cyc = -1; done_cyc = -1;
        repeat (9) step();
        check("t3_count", n_rec, 5);
        check("t3_r0", rec_row[0], 8'd1);
        check("t3_r1", rec_row[1], 8'd2);
        check("t3_r2", rec_row[2], 8'd3);
        check("t3_r3", rec_row[3], 8'd4);
        check("t3_r4", rec_row[4], 8'd6);
        check("t3_consecutive", rec_cyc[4] - rec_cyc[0], 4);
        check("t3_done_lat", done_cyc - last_pop_cyc, 2);
        check("t3_err", order_err, 1'b0);
        mode = 1'b0;
        step();
        reset_pulse();

        // Backpressure holds the output and stops pops
        mode = 1'b1; blk_done = 4'b1111; out_ready = 1'b1;
        push(0, mk(8'd1, 1'b1)); push(0, mk(8'd2, 1'b1)); push(0, mk(8'd3, 1'b1));
        step();
        step();
        out_ready = 1'b0;
        repeat (3) begin
            drive_fifos(); #1;
            check("t4_no_pop", en_intake, 4'b0000);
            check("t4_hold", data_out[W-1 -: R], 8'd1);
            step();
        end
        out_ready = 1'b1;
        drive_fifos(); #1;
        check("t4_hs_pop", en_intake, 4'b0001);
        repeat (4) step();
        mode = 1'b0;
        step();

        // Invalid head (row 7) is dropped without touching last_row
        mode = 1'b1;
        push(0, mk(8'd7, 1'b0)); push(0, mk(8'd4, 1'b1));
        step();
        step();
        check("t5_no_valid", data_out_valid, 1'b0);
        step();
        check("t5_row", data_out[W-1 -: R], 8'd4);
        check("t5_err", order_err, 1'b0);
        repeat (3) step();
        mode = 1'b0;
        step();

        // Async reset mid-merge, then an out-of-order pair 8 -> 3
        reset_pulse();
        mode = 1'b1; blk_done = 4'b1111;
        push(0, mk(8'd10, 1'b1)); push(0, mk(8'd11, 1'b1)); push(0, mk(8'd12, 1'b1));
        step();
        step();
        step();
        check("t6_pre_valid", data_out_valid, 1'b1);
        reset_pulse();
        blk_done = 4'b1110;
        push(0, mk(8'd8, 1'b1));
        step();
        step();
        blk_done = 4'b1100;
        push(1, mk(8'd3, 1'b1));
        step();
        blk_done = 4'b1101;
        step();
        step();
        check("t6_err_set", order_err, 1'b1);
        repeat (4) step();
        check("t6_err_sticky", order_err, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
